virtual_input_bank: RTL and testbench

Parametrised, clocked successor of the toggle-only virtual input generator. Drives a bank of NUM_BUTTONS active-low virtual push-buttons and NUM_SWITCHES active-high virtual slide switches into the MIC-1 board top level from a host/JTAG-style command strobe. Supports four command modes: toggle, timed pulse, set and clear. A single pulse FSM provides momentary button presses of fixed length.

---
 rtl/virtual_input_bank.sv | 201 ++++++++++++++++++++
 tb/tb_virtual_input_bank.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/virtual_input_bank.sv
// Virtual push-button / slide-switch bank driven by a host command strobe.
// Optional input synchronizer enabled by defining VIRTUAL_INPUT_SYNC_EN.
module virtual_input_bank #(
    parameter int NUM_BUTTONS  = 4,
    parameter int NUM_SWITCHES = 18,
    parameter int SEL_W        = 5,
    parameter int PULSE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    control,
    input  logic [SEL_W-1:0]        number,
    input  logic [1:0]              mode,
    output logic [NUM_BUTTONS-1:0]  buttons,
    output logic [NUM_SWITCHES-1:0] switches,
    output logic                    busy,
    output logic                    cmd_ack,
    output logic                    overrun
);

    localparam int NCH   = NUM_BUTTONS + NUM_SWITCHES;
    localparam int CNT_W = (PULSE_CYCLES > 2) ? $clog2(PULSE_CYCLES) : 1;
    localparam int IN_W  = SEL_W + 3;

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_PULSE  = 2'b01;
    localparam logic [1:0] MODE_SET    = 2'b10;
    localparam logic [1:0] MODE_CLEAR  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } state_t;

    logic             in_ctrl_s;
    logic [SEL_W-1:0] in_num_s;
    logic [1:0]       in_mode_s;

`ifdef VIRTUAL_INPUT_SYNC_EN
    logic [IN_W-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer so the host strobe may be fully asynchronous
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= {IN_W{1'b0}};
            sync2_q <= {IN_W{1'b0}};
        end else begin
            sync1_q <= {control, number, mode};
            sync2_q <= sync1_q;
        end
    end

    assign in_ctrl_s = sync2_q[IN_W-1];
    assign in_num_s  = sync2_q[IN_W-2:2];
    assign in_mode_s = sync2_q[1:0];
`else
    assign in_ctrl_s = control;
    assign in_num_s  = number;
    assign in_mode_s = mode;
`endif

    state_t                  state_q, state_d;
    logic                    ctrl_q, ctrl_d;
    logic                    fire_q, fire_d;
    logic [SEL_W-1:0]        cmd_num_q, cmd_num_d;
    logic [1:0]              cmd_mode_q, cmd_mode_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SEL_W-1:0]        pch_q, pch_d;
    logic                    saved_q, saved_d;
    logic [NUM_BUTTONS-1:0]  buttons_q, buttons_d;
    logic [NUM_SWITCHES-1:0] switches_q, switches_d;
    logic                    busy_q, busy_d;
    logic                    ack_q, ack_d;
    logic                    overrun_q, overrun_d;

    // Channels are handled as one vector where 1 means asserted
    logic [NCH-1:0] act_cur_s, act_nxt_s;
    logic           base_s;

    // Next-state: edge detect, pulse timer and command application
    always_comb begin
        ctrl_d     = in_ctrl_s;
        fire_d     = in_ctrl_s & ~ctrl_q;
        cmd_num_d  = in_num_s;
        cmd_mode_d = in_mode_s;

        state_d   = state_q;
        cnt_d     = cnt_q;
        pch_d     = pch_q;
        saved_d   = saved_q;
        overrun_d = overrun_q;
        ack_d     = 1'b0;
        base_s    = 1'b0;

        for (int i = 0; i < NUM_BUTTONS; i++) begin
            act_cur_s[i] = ~buttons_q[NUM_BUTTONS-1-i];
        end
        for (int j = 0; j < NUM_SWITCHES; j++) begin
            act_cur_s[NUM_BUTTONS+j] = switches_q[NUM_SWITCHES-1-j];
        end
        act_nxt_s = act_cur_s;

        if (state_q == ST_PULSE) begin
            if (cnt_q == {CNT_W{1'b0}}) begin
                act_nxt_s[pch_q] = saved_q;
                state_d          = ST_IDLE;
            end else begin
                cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = cnt_q;
        end

        // A later command to the pulsing channel overrides the expiry restore above
        if (fire_q) begin
            if (cmd_num_q >= SEL_W'(NCH)) begin
                act_nxt_s = {NCH{1'b0}};
                state_d   = ST_IDLE;
                cnt_d     = {CNT_W{1'b0}};
                saved_d   = 1'b0;
                overrun_d = 1'b0;
                ack_d     = 1'b1;
            end else if (cmd_mode_q == MODE_PULSE) begin
                if (state_q == ST_PULSE) begin
                    overrun_d = 1'b1;
                end else begin
                    saved_d              = act_cur_s[cmd_num_q];
                    act_nxt_s[cmd_num_q] = 1'b1;
                    cnt_d                = CNT_W'(PULSE_CYCLES - 1);
                    pch_d                = cmd_num_q;
                    state_d              = ST_PULSE;
                    ack_d                = 1'b1;
                end
            end else begin
                if ((state_q == ST_PULSE) && (cmd_num_q == pch_q)) begin
                    base_s  = saved_q;
                    state_d = ST_IDLE;
                end else begin
                    base_s = act_cur_s[cmd_num_q];
                end
                case (cmd_mode_q)
                    MODE_TOGGLE: act_nxt_s[cmd_num_q] = ~base_s;
                    MODE_SET:    act_nxt_s[cmd_num_q] = 1'b1;
                    MODE_CLEAR:  act_nxt_s[cmd_num_q] = 1'b0;
                    default:     act_nxt_s[cmd_num_q] = base_s;
                endcase
                ack_d = 1'b1;
            end
        end else begin
            ack_d = 1'b0;
        end

        for (int i = 0; i < NUM_BUTTONS; i++) begin
            buttons_d[NUM_BUTTONS-1-i] = ~act_nxt_s[i];
        end
        for (int j = 0; j < NUM_SWITCHES; j++) begin
            switches_d[NUM_SWITCHES-1-j] = act_nxt_s[NUM_BUTTONS+j];
        end
        busy_d = (state_d == ST_PULSE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= 1'b0;
            fire_q     <= 1'b0;
            cmd_num_q  <= {SEL_W{1'b0}};
            cmd_mode_q <= 2'b00;
            cnt_q      <= {CNT_W{1'b0}};
            pch_q      <= {SEL_W{1'b0}};
            saved_q    <= 1'b0;
            buttons_q  <= {NUM_BUTTONS{1'b1}};
            switches_q <= {NUM_SWITCHES{1'b0}};
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            fire_q     <= fire_d;
            cmd_num_q  <= cmd_num_d;
            cmd_mode_q <= cmd_mode_d;
            cnt_q      <= cnt_d;
            pch_q      <= pch_d;
            saved_q    <= saved_d;
            buttons_q  <= buttons_d;
            switches_q <= switches_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            overrun_q  <= overrun_d;
        end
    end

    assign buttons  = buttons_q;
    assign switches = switches_q;
    assign busy     = busy_q;
    assign cmd_ack  = ack_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_virtual_input_bank.sv
// Randomized bench for virtual_input_bank against a timestamp-based channel model.
module tb_virtual_input_bank;

    localparam int NB  = 4;
    localparam int NS  = 18;
    localparam int SW  = 5;
    localparam int P   = 16;
    localparam int NCH = NB + NS;
`ifdef VIRTUAL_INPUT_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          control;
    logic [SW-1:0] number;
    logic [1:0]    mode;
    logic [NB-1:0] buttons;
    logic [NS-1:0] switches;
    logic          busy, cmd_ack, overrun;

    virtual_input_bank #(
        .NUM_BUTTONS(NB), .NUM_SWITCHES(NS), .SEL_W(SW), .PULSE_CYCLES(P)
    ) dut (
        .clk(clk), .reset(reset), .control(control), .number(number), .mode(mode),
        .buttons(buttons), .switches(switches), .busy(busy), .cmd_ack(cmd_ack),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int at_cyc;
        int num;
        int md;
    } cmd_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   act[NCH];
    bit   pulse_active, saved, ovr, ack_exp, prev_ctrl;
    int   pch, pulse_end;
    cmd_t pend[$];

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) act[i] = 1'b0;
        pulse_active = 1'b0;
        saved        = 1'b0;
        ovr          = 1'b0;
        ack_exp      = 1'b0;
        prev_ctrl    = 1'b0;
        pch          = 0;
        pulse_end    = 0;
        pend.delete();
    endtask

    task automatic apply_cmd(input cmd_t c, input bit was_active);
        bit base;
        if (c.num >= NCH) begin
            for (int i = 0; i < NCH; i++) act[i] = 1'b0;
            pulse_active = 1'b0;
            ovr          = 1'b0;
            ack_exp      = 1'b1;
        end else if (c.md == 1) begin
            if (was_active) begin
                ovr = 1'b1;
            end else begin
                saved        = act[c.num];
                act[c.num]   = 1'b1;
                pulse_active = 1'b1;
                pch          = c.num;
                pulse_end    = cyc + P;
                ack_exp      = 1'b1;
            end
        end else begin
            if (was_active && c.num == pch) begin
                base         = saved;
                pulse_active = 1'b0;
            end else begin
                base = act[c.num];
            end
            act[c.num] = (c.md == 0) ? !base : (c.md == 2);
            ack_exp    = 1'b1;
        end
    endtask

    task automatic model_edge();
        bit was_active;
        cyc++;
        if (reset) begin
            model_reset();
        end else begin
            ack_exp    = 1'b0;
            was_active = pulse_active;
            if (pulse_active && cyc == pulse_end) begin
                act[pch]     = saved;
                pulse_active = 1'b0;
            end
            while (pend.size() > 0 && pend[0].at_cyc == cyc) apply_cmd(pend.pop_front(), was_active);
            if (control && !prev_ctrl) pend.push_back('{cyc + LAT - 1, int'(number), int'(mode)});
            prev_ctrl = control;
        end
    endtask

    task automatic compare_all();
        logic [NB-1:0] eb;
        logic [NS-1:0] es;
        for (int i = 0; i < NB; i++) eb[NB-1-i] = ~act[i];
        for (int j = 0; j < NS; j++) es[NS-1-j] = act[NB+j];
        chk_val("buttons",  32'(buttons),  32'(eb));
        chk_val("switches", 32'(switches), 32'(es));
        chk_val("busy",     32'(busy),     32'(pulse_active));
        chk_val("cmd_ack",  32'(cmd_ack),  32'(ack_exp));
        chk_val("overrun",  32'(overrun),  32'(ovr));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic issue(input int num, input int md, input int hi, input int lo);
        control = 1'b1;
        number  = SW'(num);
        mode    = 2'(md);
        repeat (hi) tick();
        control = 1'b0;
        repeat (lo) tick();
    endtask

    initial begin
        int n, hi, lo;
        reset   = 1'b1;
        control = 1'b0;
        number  = '0;
        mode    = 2'b00;
        model_reset();
        repeat (3) tick();
        chk_val("reset_buttons", 32'(buttons), 32'hF);
        reset = 1'b0;
        tick();

        issue(0, 0, 1, 3);
        issue(0, 0, 2, 3);
        issue(4, 2, 1, 3);
        issue(21, 3, 1, 3);
        issue(4, 2, 3, 3);
        issue(2, 1, 1, 4);
        issue(2, 1, 1, 4);
        issue(2, 0, 1, 3);
        issue(31, 2, 1, 3);
        issue(2, 1, 1, 20);
        issue(2, 1, 1, 7);

        // Asynchronous reset in the middle of a pulse
        #2 reset = 1'b1;
        #1;
        chk_val("async_buttons", 32'(buttons), 32'hF);
        chk_val("async_busy",    32'(busy),    32'h0);
        chk_val("async_ovr",     32'(overrun), 32'h0);
        model_reset();
        @(negedge clk);
        tick();
        reset = 1'b0;
        tick();

        for (int k = 0; k < 300; k++) begin
            n = $urandom_range(0, 31);
            if (n >= NCH && $urandom_range(0, 7) != 0) n = n % NCH;
            hi = $urandom_range(1, 3);
            lo = ($urandom_range(0, 9) == 0) ? 18 : $urandom_range(1, 4);
            issue(n, $urandom_range(0, 3), hi, lo);
        end
        repeat (P + LAT + 2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
